s526_bist_ctrl: RTL

S526_BIST_CTRL -- requirements
Module: s526_bist_ctrl

---
 rtl/s526_bist_pkg.sv | 21 ++
 rtl/s526_bist_ctrl_if.sv | 26 ++
 rtl/s526_bist_ctrl_lfsr16.sv | 39 +++
 rtl/s526_bist_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/s526_bist_pkg.sv
// Shared types and constants for the s526 BIST controller: FSM states,
// LFSR/MISR feedback taps and the default pattern seed.
package s526_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_FLUSH,
        ST_FIN
    } state_e;

    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [15:0] FB_TAPS           = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    function automatic logic [15:0] shift_fb(input logic [15:0] v);
        return {v[14:0], ^(v & FB_TAPS)};
    endfunction

endpackage

// File: rtl/s526_bist_ctrl_if.sv
// Control, status and DUT-facing signals of the s526 BIST controller.
interface s526_bist_ctrl_if;

    logic        START;
    logic [7:0]  NPAT;
    logic [15:0] GOLDEN;
    logic [5:0]  DUT_OUT;
    logic        DUT_G0;
    logic        DUT_G1;
    logic        DUT_G2;
    logic        BUSY;
    logic        DONE;
    logic [15:0] SIG;
    logic        PASS;

    modport slave (
        input  START, NPAT, GOLDEN, DUT_OUT,
        output DUT_G0, DUT_G1, DUT_G2, BUSY, DONE, SIG, PASS
    );

    modport master (
        output START, NPAT, GOLDEN, DUT_OUT,
        input  DUT_G0, DUT_G1, DUT_G2, BUSY, DONE, SIG, PASS
    );

endinterface

// File: rtl/s526_bist_ctrl_lfsr16.sv
// 16-bit feedback shift register with parallel data-in and load; serves as
// the pattern generator (data-in tied to 0) and as the signature MISR.
module lfsr16
    import s526_bist_pkg::*;
#(
    parameter logic [15:0] INIT_VAL = 16'h0000,
    parameter int unsigned OUT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [15:0]      din,
    output logic [OUT_W-1:0] q
);

    logic [15:0] val_q;
    logic [15:0] val_d;

    always_comb begin
        val_d = val_q;
        if (load) begin
            val_d = INIT_VAL;
        end else if (en) begin
            val_d = shift_fb(val_q) ^ din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q <= INIT_VAL;
        end else begin
            val_q <= val_d;
        end
    end

    assign q = val_q[OUT_W-1:0];

endmodule

// File: rtl/s526_bist_ctrl.sv
// BIST sequencer for an s526 core: clears it, applies NPAT LFSR patterns to
// G1/G2, compacts the outputs into a MISR and compares against GOLDEN.
module s526_bist_ctrl
    import s526_bist_pkg::*;
#(
    parameter int unsigned INIT_CYC  = 2,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input logic              CK,
    input logic              RST,
    s526_bist_ctrl_if.slave  bus
);

    localparam logic [3:0] INIT_LAST = 4'(INIT_CYC - 1);

    state_e      state_q, state_d;
    logic [7:0]  pat_cnt_q, pat_cnt_d;
    logic [3:0]  init_cnt_q, init_cnt_d;
    logic        first_q, first_d;
    logic [15:0] golden_q, golden_d;
    logic [15:0] sig_q, sig_d;
    logic        pass_q, pass_d;

    logic        start_acc;
    logic        gen_en;
    logic        misr_en;
    logic [1:0]  gen_bits;
    logic [15:0] misr_q;
    logic [15:0] misr_din;
    logic [15:0] misr_upd;

    assign misr_din = {10'b0, bus.DUT_OUT};
    assign misr_upd = shift_fb(misr_q) ^ misr_din;

    always_comb begin
        state_d    = state_q;
        pat_cnt_d  = pat_cnt_q;
        init_cnt_d = init_cnt_q;
        first_d    = first_q;
        golden_d   = golden_q;
        sig_d      = sig_q;
        pass_d     = pass_q;
        start_acc  = 1'b0;
        gen_en     = 1'b0;
        misr_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    start_acc  = 1'b1;
                    state_d    = ST_INIT;
                    pat_cnt_d  = bus.NPAT;
                    init_cnt_d = '0;
                    golden_d   = bus.GOLDEN;
                    sig_d      = '0;
                    pass_d     = 1'b0;
                end
            end
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 4'd1;
                if (init_cnt_q == INIT_LAST) begin
                    init_cnt_d = '0;
                    first_d    = 1'b1;
                    state_d    = (pat_cnt_q == 8'd0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                // The core answers one cycle late, so the first RUN cycle
                // has nothing to compact yet.
                gen_en    = 1'b1;
                misr_en   = !first_q;
                first_d   = 1'b0;
                pat_cnt_d = pat_cnt_q - 8'd1;
                if (pat_cnt_q == 8'd1) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                misr_en = 1'b1;
                state_d = ST_FIN;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Capture the result on entry to FIN so SIG/PASS are valid with DONE.
        if (state_d == ST_FIN && state_q != ST_FIN) begin
            sig_d  = misr_en ? misr_upd : misr_q;
            pass_d = (sig_d == golden_q);
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            pat_cnt_q  <= '0;
            init_cnt_q <= '0;
            first_q    <= 1'b0;
            golden_q   <= '0;
            sig_q      <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_cnt_q  <= pat_cnt_d;
            init_cnt_q <= init_cnt_d;
            first_q    <= first_d;
            golden_q   <= golden_d;
            sig_q      <= sig_d;
            pass_q     <= pass_d;
        end
    end

    lfsr16 #(.INIT_VAL(LFSR_SEED), .OUT_W(2)) u_gen (
        .clk  (CK),
        .rst  (RST),
        .load (start_acc),
        .en   (gen_en),
        .din  (16'h0000),
        .q    (gen_bits)
    );

    lfsr16 #(.INIT_VAL(16'h0000), .OUT_W(16)) u_misr (
        .clk  (CK),
        .rst  (RST),
        .load (start_acc),
        .en   (misr_en),
        .din  (misr_din),
        .q    (misr_q)
    );

    assign bus.BUSY   = (state_q != ST_IDLE);
    assign bus.DONE   = (state_q == ST_FIN);
    assign bus.DUT_G0 = RST || (state_q == ST_INIT);
    assign bus.DUT_G1 = !RST && (state_q == ST_RUN) && gen_bits[0];
    assign bus.DUT_G2 = !RST && (state_q == ST_RUN) && gen_bits[1];
    assign bus.SIG    = sig_q;
    assign bus.PASS   = pass_q;

endmodule
